// File: rtl/md_exec_unit.sv
// rtl/md_exec_unit.sv - E-stage operand forwarding plus multi-cycle MULT/DIV engine with HI/LO
//
// Optional feature macro: MD_CANCEL_EN (md_cancel aborts an in-flight op when defined).
//
// Ports:
//   clk, reset_n             clock; synchronous active-low reset
//   rs_rf, rt_rf             register-file operands
//   alu_out_m, result_w,     forwarding sources
//   pc_m
//   fwd_a_sel, fwd_b_sel     00 rf, 01 alu_out_m, 10 result_w, 11 pc_m+LINK_OFFSET
//   md_valid, md_op          instruction-in-E qualifier and MD opcode
//   md_cancel                abort request for the in-flight op
//   src_a, src_b             forwarded operands (combinational)
//   start                    MD arithmetic op accepted this cycle (combinational)
//   busy                     operation in flight (registered)
//   hi, lo                   HI/LO registers
module md_exec_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_LAT    = 5,
  parameter int DIV_LAT     = 10,
  parameter int LINK_OFFSET = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] rs_rf,
  input  logic [WIDTH-1:0] rt_rf,
  input  logic [WIDTH-1:0] alu_out_m,
  input  logic [WIDTH-1:0] result_w,
  input  logic [WIDTH-1:0] pc_m,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic             md_valid,
  input  logic [2:0]       md_op,
  input  logic             md_cancel,
  output logic [WIDTH-1:0] src_a,
  output logic [WIDTH-1:0] src_b,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic cancel_eff;
`ifdef MD_CANCEL_EN
  assign cancel_eff = md_cancel;
`else
  // Port kept for a uniform interface; it has no effect in this build.
  assign cancel_eff = md_cancel & 1'b0;
`endif

  // Forwarding muxes
  always_comb begin
    src_a = rs_rf;
    case (fwd_a_sel)
      2'b01:   src_a = alu_out_m;
      2'b10:   src_a = result_w;
      2'b11:   src_a = pc_m + WIDTH'(LINK_OFFSET);
      default: src_a = rs_rf;
    endcase
  end

  always_comb begin
    src_b = rt_rf;
    case (fwd_b_sel)
      2'b01:   src_b = alu_out_m;
      2'b10:   src_b = result_w;
      2'b11:   src_b = pc_m + WIDTH'(LINK_OFFSET);
      default: src_b = rt_rf;
    endcase
  end

  logic is_arith;
  assign is_arith = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign busy  = (state_q == ST_RUN);
  assign start = md_valid && !busy && is_arith;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Result datapath: operates only on latched operands.
  logic [2*WIDTH-1:0]        prod_s, prod_u;
  logic signed [WIDTH-1:0]   sa, sb;
  logic [WIDTH-1:0]          quot_s, rem_s, quot_u, rem_u;
  logic                      div_ovf, div_zero;

  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign sa     = $signed(a_q);
  assign sb     = $signed(b_q);
  assign div_zero = (b_q == '0);
  // MIN / -1 overflows the signed quotient; pinned to LO=MIN, HI=0.
  assign div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
  assign quot_s = div_zero ? '0 : (div_ovf ? a_q : $unsigned(sa / sb));
  assign rem_s  = (div_zero || div_ovf) ? '0 : $unsigned(sa % sb);
  assign quot_u = div_zero ? '0 : (a_q / b_q);
  assign rem_u  = div_zero ? '0 : (a_q % b_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          op_d    = md_op;
          a_d     = src_a;
          b_d     = src_b;
          count_d = ((md_op == OP_MULT) || (md_op == OP_MULTU)) ?
                    CW'(MULT_LAT - 1) : CW'(DIV_LAT - 1);
        end else if (md_valid && (md_op == OP_MTHI)) begin
          hi_d = src_a;
        end else if (md_valid && (md_op == OP_MTLO)) begin
          lo_d = src_a;
        end
      end
      ST_RUN: begin
        if (cancel_eff) begin
          // Abort beats completion: no HI/LO write.
          state_d = ST_IDLE;
          count_d = '0;
          op_d    = OP_NONE;
        end else if (count_q == '0) begin
          state_d = ST_IDLE;
          op_d    = OP_NONE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: if (!div_zero) begin
              lo_d = quot_s;
              hi_d = rem_s;
            end
            OP_DIVU: if (!div_zero) begin
              lo_d = quot_u;
              hi_d = rem_u;
            end
            default: ;
          endcase
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_exec_unit.sv
// tb/tb_md_exec_unit.sv - directed self-checking bench for md_exec_unit
module tb_md_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rs_rf, rt_rf, alu_out_m, result_w, pc_m;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        md_valid;
  logic [2:0]  md_op;
  logic        md_cancel;
  logic [31:0] src_a, src_b, hi, lo;
  logic        start, busy;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  md_exec_unit dut (
    .clk(clk), .reset_n(reset_n),
    .rs_rf(rs_rf), .rt_rf(rt_rf),
    .alu_out_m(alu_out_m), .result_w(result_w), .pc_m(pc_m),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .md_valid(md_valid), .md_op(md_op), .md_cancel(md_cancel),
    .src_a(src_a), .src_b(src_b), .start(start), .busy(busy),
    .hi(hi), .lo(lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one MD arithmetic op from rf operands and count busy cycles.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    rs_rf     = a;
    rt_rf     = b;
    md_valid  = 1'b1;
    md_op     = op;
    #1;
    chk({tag, "_start"}, {63'd0, start}, 64'd1);
    step();
    md_valid = 1'b0;
    md_op    = 3'd0;
    // Scramble forwarding inputs: latched operands must be used.
    rs_rf    = 32'h0BAD_F00D;
    rt_rf    = 32'h0000_0003;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0; rs_rf = '0; rt_rf = '0; alu_out_m = '0; result_w = '0; pc_m = '0;
    fwd_a_sel = '0; fwd_b_sel = '0; md_valid = 1'b0; md_op = '0; md_cancel = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);

    // Forwarding muxes
    pc_m = 32'h0000_3000; alu_out_m = 32'h1234_5678; result_w = 32'hCAFE_0001;
    rs_rf = 32'h1111_1111; rt_rf = 32'h2222_2222;
    fwd_a_sel = 2'b11; fwd_b_sel = 2'b01; #1;
    chk("fwd_a_pc", {32'd0, src_a}, 64'h0000_3004);
    chk("fwd_b_alu", {32'd0, src_b}, 64'h1234_5678);
    fwd_a_sel = 2'b10; fwd_b_sel = 2'b00; #1;
    chk("fwd_a_wb", {32'd0, src_a}, 64'hCAFE_0001);
    chk("fwd_b_rf", {32'd0, src_b}, 64'h2222_2222);
    pc_m = 32'hFFFF_FFFE; fwd_b_sel = 2'b11; #1;
    chk("fwd_b_pc_wrap", {32'd0, src_b}, 64'h0000_0002);

    // start qualifiers
    md_valid = 1'b0; md_op = 3'd1; #1;
    chk("start_novalid", {63'd0, start}, 64'd0);
    md_valid = 1'b1; md_op = 3'd7; #1;
    chk("start_reserved", {63'd0, start}, 64'd0);
    md_valid = 1'b0; md_op = 3'd0;

    // MULT -3 x 5
    issue(3'd1, 32'hFFFF_FFFD, 32'd5, "mult");
    wait_done(n);
    chk("mult_lat", 64'(n), 64'd5);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // MULTU same operands
    issue(3'd2, 32'hFFFF_FFFD, 32'd5, "multu");
    wait_done(n);
    chk("multu_lat", 64'(n), 64'd5);
    chk("multu_hilo", {hi, lo}, 64'h0000_0004_FFFF_FFF1);

    // DIVU 7/2
    issue(3'd4, 32'd7, 32'd2, "divu");
    wait_done(n);
    chk("divu_lat", 64'(n), 64'd10);
    chk("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

    // DIV -7/2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    wait_done(n);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV MIN/-1
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    wait_done(n);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // DIV by zero: full latency, HI/LO unchanged
    issue(3'd3, 32'd5, 32'd0, "div_zero");
    wait_done(n);
    chk("div_zero_lat", 64'(n), 64'd10);
    chk("div_zero_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI while busy is ignored
    issue(3'd4, 32'd7, 32'd2, "divu2");
    md_valid = 1'b1; md_op = 3'd5; rs_rf = 32'hAAAA_5555; fwd_a_sel = 2'b00; #1;
    chk("mthi_busy_start", {63'd0, start}, 64'd0);
    step();
    md_valid = 1'b0; md_op = 3'd0;
    wait_done(n);
    chk("divu2_lat", 64'(n + 1), 64'd10);
    chk("mthi_busy_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

    // MTHI / MTLO when idle
    md_valid = 1'b1; md_op = 3'd5; rs_rf = 32'hAAAA_5555; #1;
    chk("mthi_start", {63'd0, start}, 64'd0);
    step();
    chk("mthi_hi", {32'd0, hi}, 64'hAAAA_5555);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    md_op = 3'd6; rs_rf = 32'h1234_5678;
    step();
    md_valid = 1'b0; md_op = 3'd0;
    chk("mtlo_hilo", {hi, lo}, 64'hAAAA_5555_1234_5678);

    // Reset during third busy cycle of MULT
    issue(3'd1, 32'd3, 32'd4, "mult_rst");
    step();
    step();
    chk("mult_rst_busy3", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < 6; i++) step();
    chk("rst_no_late_write", {hi, lo}, 64'd0);
    chk("rst_no_late_busy", {63'd0, busy}, 64'd0);

    // Cancel mid-DIV
    issue(3'd3, 32'd100, 32'd7, "div_cancel");
    step();
    step();
    md_cancel = 1'b1;
    step();
    md_cancel = 1'b0;
`ifdef MD_CANCEL_EN
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 12; i++) step();
    chk("cancel_hilo", {hi, lo}, 64'd0);
`else
    chk("nocancel_busy", {63'd0, busy}, 64'd1);
    wait_done(n);
    chk("nocancel_lat", 64'(n + 3), 64'd10);
    chk("nocancel_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_exec_unit.md
# md_exec_unit

Parametrised execute-stage operand and multiply/divide block for the pipelined MIPS core. It extends the existing E-stage forwarding muxes with a multi-cycle MULT/MULTU/DIV/DIVU engine, HI/LO registers and MTHI/MTLO writes. It sits in E beside the ALU and feeds it the forwarded operands. Its `busy`/`start` outputs drive the hazard unit's stall on MD-class instructions in D.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; HI, LO and operands are all `WIDTH` bits.
- `MULT_LAT`, 5: busy cycles for MULT/MULTU; legal range is 1 or more.
- `DIV_LAT`, 10: busy cycles for DIV/DIVU; legal range is 1 or more.
- `LINK_OFFSET`, 4: added to `pc_m` when forward select is 2'b11.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `rs_rf`, `rt_rf`  in  WIDTH  register-file operands.
- `alu_out_m`, `result_w`, `pc_m`  in  WIDTH  forwarding sources.
- `fwd_a_sel`, `fwd_b_sel`  in  2  forward select: 00 rf, 01 alu_out_m, 10 result_w, 11 pc_m+LINK_OFFSET.
- `md_valid`  in  1  a non-bubble instruction is in E.
- `md_op`  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- `md_cancel`  in  1  abort the in-flight operation (see Configuration).
- `src_a`, `src_b`  out  WIDTH  forwarded operands to the ALU and data path (combinational).
- `start`  out  1  combinational; an MD arithmetic op is accepted this cycle.
- `busy`  out  1  registered; an operation is in flight.
- `hi`, `lo`  out  WIDTH  registered HI/LO.

## Operation
- `src_a` and `src_b` are pure 4-way muxes. The 11 input computes `pc_m + LINK_OFFSET` modulo 2^WIDTH.
- Idle→RUN: when `md_valid`, `busy`=0 and `md_op` is in 001–100, `start`=1. At that edge the block latches `src_a`/`src_b`, the op and count = latency−1, and `busy` rises.
- RUN: count decrements each cycle. On the edge where `busy`=1 and count=0, the result is written to HI/LO and `busy` falls.
- MULT/MULTU: {HI,LO} = 2·WIDTH-bit signed or unsigned product.
- DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed MIN/−1 gives LO=MIN, HI=0.
  - Divide by zero leaves HI/LO unchanged but still runs the full `DIV_LAT`.
- MTHI/MTLO: with `md_valid` and `busy`=0, HI or LO takes `src_a` at the edge. No busy phase.
- Any MD op presented while `busy`=1 is ignored; `start` stays 0. The hazard unit must stall D, which guarantees this never happens in normal flow.
- Result computation uses latched operands only. Forward-input changes during RUN have no effect.

## Timing
- Reset (edge with `reset_n`=0): `hi`=0, `lo`=0, `busy`=0, count=0, latched op=none. This overrides any in-flight op and any simultaneous write.
- Start at edge T0: `busy`=1 for cycles T0+1 … T0+LAT. New HI/LO are visible from cycle T0+LAT+1, the same cycle `busy` reads 0.
- A new op may start in the first cycle `busy`=0. There are no back-to-back bubbles beyond LAT.
- MTHI/MTLO write is visible the cycle after the edge.
- `start`, `src_a` and `src_b` have zero latency (combinational). `busy`, `hi` and `lo` have no combinational path from inputs.

## Configuration
- `MD_CANCEL_EN` defined: `md_cancel`=1 at an edge while `busy`=1 clears `busy` and count and leaves HI/LO unchanged.
  - Cancel on the completion edge wins: no write.
  - Cancel has priority over a simultaneous start: no start is taken.
- `MD_CANCEL_EN` undefined: the `md_cancel` port exists but is ignored. Every started op always completes.

## Test plan
- Forwarding: `pc_m`=0x00003000, `fwd_a_sel`=11 → `src_a`=0x00003004. `fwd_b_sel`=01, `alu_out_m`=0x12345678 → `src_b`=0x12345678.
- MULT −3×5 (0xFFFFFFFD, 5) → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU of the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIVU 7/2 → after 10 busy cycles LO=3, HI=1. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/−1 → LO=0x80000000, HI=0. DIV by 0 → HI/LO unchanged.
- MTHI 0xAAAA5555 while busy → ignored. After the op completes, MTHI 0xAAAA5555 → HI=0xAAAA5555 next cycle, with `busy` never asserted.
- `reset_n`=0 at the third busy cycle of MULT → next cycle `busy`=0, HI=LO=0. No late write occurs.
- With `MD_CANCEL_EN`: cancel mid-DIV → `busy`=0 next cycle, HI/LO keep their prior values. Without the macro → the same stimulus completes normally.
